// File: rtl/hash_mem_dma.sv
// ============================================================================
// Module : hash_mem_dma
// Burst read/write initiator for the hash co-processor's single-port word memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hash_mem_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_index,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_TAIL = 3'd2,
    WR      = 3'd3,
    WR_TAIL = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic              req_valid;
  logic [LEN_W-1:0]  req_idx;
  logic [LEN_W-1:0]  cnt_next;
  logic              handshake;

  assign mem_clk   = clk;
  assign cnt_next  = cnt + LEN_W'(1);
  assign handshake = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      len            <= '0;
      cnt            <= '0;
      req_valid      <= 1'b0;
      req_idx        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_index      <= '0;
      in_ready       <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      done      <= 1'b0;
      req_valid <= 1'b0;
      // Read data returns one cycle after its address; register it one more cycle.
      out_valid <= req_valid;
      if (req_valid) begin
        out_data  <= mem_read_data;
        out_index <= req_idx;
      end
      case (state)
        IDLE: begin
          if (start) begin
            base <= cmd_addr;
            len  <= cmd_len;
            cnt  <= '0;
            if (cmd_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (!cmd_we) begin
              state    <= RD;
              busy     <= 1'b1;
              mem_addr <= cmd_addr;
            end else begin
              state    <= WR;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        RD: begin
          req_valid <= 1'b1;
          req_idx   <= cnt;
          if (cnt == len - LEN_W'(1)) begin
            state <= RD_TAIL;
          end else begin
            cnt      <= cnt_next;
            mem_addr <= base + ADDR_W'(cnt_next);
          end
        end
        RD_TAIL: begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        WR: begin
          mem_we <= handshake;
          if (handshake) begin
            mem_addr       <= base + ADDR_W'(cnt);
            mem_write_data <= in_data;
            cnt            <= cnt_next;
            if (cnt_next == len) begin
              in_ready <= 1'b0;
              state    <= WR_TAIL;
            end
          end
        end
        WR_TAIL: begin
          mem_we <= 1'b0;
          state  <= FIN;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hash_mem_dma.sv
// ============================================================================
// Module : tb_hash_mem_dma
// Directed bench for hash_mem_dma with a per-cycle expectation schedule.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hash_mem_dma;
  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        busy, done, out_valid, in_ready, mem_clk, mem_we;
  logic [31:0] out_data, mem_write_data;
  logic [7:0]  out_index;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;

  hash_mem_dma #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .busy(busy), .done(done), .out_valid(out_valid),
    .out_data(out_data), .out_index(out_index), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [65536];
  logic [31:0] ref_mem [65536];
  always @(posedge mem_clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour per cycle number
  bit        e_busy[N], e_done[N], e_outv[N], e_inrdy[N], e_we[N], e_achk[N], e_zero[N];
  bit [31:0] e_outd[N], e_wd[N];
  bit [7:0]  e_outi[N];
  bit [15:0] e_addr[N];
  bit        chk_on = 1'b0;
  int        errors = 0, checks = 0;
  int        we_cnt;
  logic [15:0] cap_addr[8];
  logic [31:0] cap_data[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < N) begin
      if (e_zero[cyc]) begin
        chk("rst_busy", 32'(busy), 0);       chk("rst_done", 32'(done), 0);
        chk("rst_outv", 32'(out_valid), 0);  chk("rst_inrdy", 32'(in_ready), 0);
        chk("rst_we", 32'(mem_we), 0);       chk("rst_outd", out_data, 0);
        chk("rst_outi", 32'(out_index), 0);  chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wd", mem_write_data, 0);
      end else begin
        chk("busy", 32'(busy), 32'(e_busy[cyc]));
        chk("done", 32'(done), 32'(e_done[cyc]));
        chk("out_valid", 32'(out_valid), 32'(e_outv[cyc]));
        chk("in_ready", 32'(in_ready), 32'(e_inrdy[cyc]));
        chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
        if (e_outv[cyc] && out_valid) begin
          chk("out_data", out_data, e_outd[cyc]);
          chk("out_index", 32'(out_index), 32'(e_outi[cyc]));
        end
        if (e_achk[cyc]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
        if (e_we[cyc] && mem_we) chk("mem_wdata", mem_write_data, e_wd[cyc]);
      end
    end
  end

  task automatic clear_from(input int c);
    for (int k = c; k < N; k++) begin
      e_busy[k] = 0; e_done[k] = 0; e_outv[k] = 0; e_inrdy[k] = 0;
      e_we[k] = 0; e_achk[k] = 0; e_zero[k] = 0;
    end
  endtask

  // Read burst; optional ignored start pulse while busy and optional reset at cycle offset rst_j.
  task automatic rd(input logic [15:0] base, input int len, input bit ign, input int rst_j);
    int s;
    @(posedge clk); #1;
    s = cyc;
    start = 1; cmd_we = 0; cmd_addr = base; cmd_len = 8'(len);
    if (len == 0) e_done[s+1] = 1;
    else begin
      for (int i = 0; i <= len; i++) e_busy[s+1+i] = 1;
      for (int i = 0; i < len; i++) begin
        e_achk[s+1+i] = 1;
        e_addr[s+1+i] = base + 16'(i);
        e_outv[s+3+i] = 1;
        e_outd[s+3+i] = ref_mem[base + 16'(i)];
        e_outi[s+3+i] = 8'(i);
      end
      e_done[s+len+2] = 1;
    end
    for (int j = 1; j <= len + 2; j++) begin
      @(posedge clk); #1;
      start = ign && (j == 2);
      cmd_we = 1; cmd_addr = 16'h0007; cmd_len = 8'd5;
      if (j <= 8) cap_addr[j-1] = mem_addr;
      if (out_valid && out_index < 4) cap_data[out_index[1:0]] = out_data;
      if (j == rst_j) begin
        reset = 1;
        clear_from(cyc + 1);
        e_zero[cyc+1] = 1;
      end else if (rst_j > 0 && j == rst_j + 1) begin
        reset = 0;
        break;
      end
    end
    start = 0;
  endtask

  // Write burst; in_valid follows pat cyclically, word k = dbase + k.
  task automatic wr(input logic [15:0] base, input int len, input logic [31:0] dbase,
                    input bit [7:0] pat, input int plen);
    int s, acc, fin, c;
    @(posedge clk); #1;
    s = cyc; acc = 0; fin = -1; we_cnt = 0;
    start = 1; cmd_we = 1; cmd_addr = base; cmd_len = 8'(len);
    if (len == 0) begin e_done[s+1] = 1; fin = s + 1; end
    for (int j = 1; j < 200; j++) begin
      @(posedge clk); #1;
      start = 0;
      c = cyc;
      if (mem_we) we_cnt++;
      if (acc < len) begin
        in_valid = pat[(j-1) % plen];
        in_data  = in_valid ? dbase + 32'(acc) : 32'hBAD0_0000 + 32'(j);
        e_busy[c] = 1; e_inrdy[c] = 1;
        if (in_valid) begin
          e_we[c+1] = 1; e_achk[c+1] = 1;
          e_addr[c+1] = base + 16'(acc);
          e_wd[c+1] = dbase + 32'(acc);
          ref_mem[base + 16'(acc)] = dbase + 32'(acc);
          acc++;
          if (acc == len) begin
            e_busy[c+1] = 1; e_done[c+2] = 1; fin = c + 2;
          end
        end
      end else begin
        in_valid = 0;
      end
      if (c == fin) break;
    end
    in_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 32'(i) * 32'h9E37_79B9;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 19; i++) begin
      mem[i] = (32'h0123_4567 << i) | (32'h0123_4567 >> (32 - i));
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1;
    e_zero[cyc+1] = 1;
    @(posedge clk); #1;
    reset = 0;

    // 19-word header fetch with an ignored start while busy
    rd(16'h0000, 19, 1'b1, 0);
    chk("hdr_w0", cap_data[0], 32'h0123_4567);
    chk("hdr_w1", cap_data[1], 32'h0246_8ACE);
    chk("hdr_w2", cap_data[2], 32'h048D_159C);

    wr(16'd1000, 16, 32'd0, 8'b1, 1);
    chk("wr16_we_cycles", 32'(we_cnt), 32'd16);
    @(posedge clk); #1;
    chk("wr16_mem_first", mem[1000], 32'd0);
    chk("wr16_mem_last", mem[1015], 32'd15);

    wr(16'd1000, 4, 32'hA0, 8'b01, 2);
    chk("wrtog_we_cycles", 32'(we_cnt), 32'd4);
    @(posedge clk); #1;
    chk("wrtog_mem3", mem[1003], 32'hA3);

    rd(16'hFFFE, 4, 1'b0, 0);
    chk("wrap_a0", 32'(cap_addr[0]), 32'h0000_FFFE);
    chk("wrap_a1", 32'(cap_addr[1]), 32'h0000_FFFF);
    chk("wrap_a2", 32'(cap_addr[2]), 32'h0000_0000);
    chk("wrap_a3", 32'(cap_addr[3]), 32'h0000_0001);

    rd(16'd100, 0, 1'b0, 0);
    wr(16'd200, 0, 32'd0, 8'b1, 1);

    // reset lands while word 2 is on the output
    rd(16'h0000, 19, 1'b0, 5);
    rd(16'd1000, 16, 1'b0, 0);
    chk("readback_w2", cap_data[2], 32'hA2);

    repeat (4) @(posedge clk);
    #1;
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
